// File: rtl/dd_fx3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dd_fx3_pkg
// Brief    : Shared types and defaults for the FX3 read-side burst sequencer.
// Revision : 1.0
// ============================================================================
package dd_fx3_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_FX3 = 3'd1,
        BURST    = 3'd2,
        DRAIN    = 3'd3,
        ERROR    = 3'd4
    } state_t;

    localparam int DEFAULT_BURST_LEN    = 8192;
    localparam int DEFAULT_READ_LATENCY = 2;

    localparam int ERR_OVERFLOW  = 0;
    localparam int ERR_UNDERFLOW = 1;

endpackage
`default_nettype wire

// File: rtl/fx3_burst_controller_valid_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : valid_delay_line
// Brief    : DEPTH-stage shift of {valid, last} aligning strobes with data.
// Revision : 1.0
// ============================================================================
module valid_delay_line #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_i,
    input  logic last_i,
    output logic valid_o,
    output logic last_o
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] last_q;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= '0;
                    last_q  <= '0;
                end else begin
                    valid_q <= valid_i;
                    last_q  <= last_i;
                end
            end
        end else begin : g_shift
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= '0;
                    last_q  <= '0;
                end else begin
                    valid_q <= {valid_q[DEPTH-2:0], valid_i};
                    last_q  <= {last_q[DEPTH-2:0], last_i};
                end
            end
        end
    endgenerate

    assign valid_o = valid_q[DEPTH-1];
    assign last_o  = last_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/fx3_burst_controller.sv
`default_nettype none
// ============================================================================
// Module   : fx3_burst_controller
// Brief    : Issues fixed-length FIFO read bursts to the FX3, tags valid/last,
//            gates ADC collection and latches sticky overflow/underflow.
// Revision : 1.0
// ============================================================================
module fx3_burst_controller
    import dd_fx3_pkg::*;
#(
    parameter int BURST_LEN    = DEFAULT_BURST_LEN,
    parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
    input  logic        fx3Clk,
    input  logic        nReset,
    input  logic        collectEnable,
    input  logic        clearErrors,
    input  logic        dataAvailable,
    input  logic        fullError,
    input  logic        emptyError,
    input  logic        fx3Ready,
    output logic        collectData,
    output logic        readData,
    output logic        fx3DataValid,
    output logic        fx3EndOfBurst,
    output logic [1:0]  errorFlags,
    output logic [15:0] burstCount
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int DRN_W = $clog2(READ_LATENCY + 1);
    localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(BURST_LEN - 1);
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(READ_LATENCY - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [DRN_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [1:0]        err_q, err_d;
    logic              collect_q;
    logic [15:0]       burst_count_q;

    logic w_read_req;
    logic w_overflow;
    logic w_underflow;
    logic w_new_err;
    logic w_read;
    logic w_last_read;
    logic w_valid;
    logic w_last;
    logic w_rst;

    // Underflow is judged on the ungated request so a simultaneous overflow
    // cannot mask it; the issued read is then suppressed by either error.
    assign w_read_req  = (state_q == BURST) && fx3Ready && (err_q == 2'b00);
    assign w_overflow  = fullError && collect_q;
    assign w_underflow = emptyError && w_read_req;
    assign w_new_err   = w_overflow || w_underflow;
    assign w_read      = w_read_req && !w_new_err;
    assign w_last_read = w_read && (word_cnt_q == LAST_WORD);

    always_comb begin
        err_d                = clearErrors ? 2'b00 : err_q;
        err_d[ERR_OVERFLOW]  = err_d[ERR_OVERFLOW] | w_overflow;
        err_d[ERR_UNDERFLOW] = err_d[ERR_UNDERFLOW] | w_underflow;
    end

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        drain_cnt_d = drain_cnt_q;
        if (w_read) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
        end
        if (w_new_err) begin
            state_d = ERROR;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dataAvailable && collectEnable && (err_q == 2'b00)) begin
                        state_d = WAIT_FX3;
                    end
                end
                WAIT_FX3: begin
                    if (fx3Ready) begin
                        state_d    = BURST;
                        word_cnt_d = '0;
                    end
                end
                BURST: begin
                    if (w_last_read) begin
                        state_d     = DRAIN;
                        drain_cnt_d = '0;
                    end
                end
                DRAIN: begin
                    drain_cnt_d = drain_cnt_q + DRN_W'(1);
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_d = IDLE;
                    end
                end
                ERROR: begin
                    if ((err_q == 2'b00) && !collectEnable) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Collection gate looks at the flags being latched this edge so that the
    // ADC side stops one cycle after the fault.
    always_ff @(posedge fx3Clk) begin
        if (!nReset) begin
            state_q       <= IDLE;
            word_cnt_q    <= '0;
            drain_cnt_q   <= '0;
            err_q         <= 2'b00;
            collect_q     <= 1'b0;
            burst_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            err_q       <= err_d;
            collect_q   <= collectEnable && (err_d == 2'b00);
            if (w_last) begin
                burst_count_q <= burst_count_q + 16'd1;
            end
        end
    end

    assign w_rst = !nReset;

    valid_delay_line #(
        .DEPTH(READ_LATENCY)
    ) u_valid_delay_line (
        .clk    (fx3Clk),
        .rst    (w_rst),
        .valid_i(w_read),
        .last_i (w_last_read),
        .valid_o(w_valid),
        .last_o (w_last)
    );

    assign readData      = w_read;
    assign collectData   = collect_q;
    assign fx3DataValid  = w_valid;
    assign fx3EndOfBurst = w_last;
    assign errorFlags    = err_q;
    assign burstCount    = burst_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fx3_burst_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_fx3_burst_controller
// Brief    : Directed and random stimulus against a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_fx3_burst_controller;

    localparam int BL = 16;
    localparam int RL = 2;
    localparam int M_IDLE  = 0;
    localparam int M_WAIT  = 1;
    localparam int M_BURST = 2;
    localparam int M_DRAIN = 3;
    localparam int M_ERROR = 4;

    logic        fx3Clk = 1'b0;
    logic        nReset = 1'b0;
    logic        collectEnable = 1'b0;
    logic        clearErrors = 1'b0;
    logic        dataAvailable = 1'b0;
    logic        fullError = 1'b0;
    logic        emptyError = 1'b0;
    logic        fx3Ready = 1'b1;
    logic        collectData;
    logic        readData;
    logic        fx3DataValid;
    logic        fx3EndOfBurst;
    logic [1:0]  errorFlags;
    logic [15:0] burstCount;

    fx3_burst_controller #(
        .BURST_LEN   (BL),
        .READ_LATENCY(RL)
    ) dut (
        .fx3Clk       (fx3Clk),
        .nReset       (nReset),
        .collectEnable(collectEnable),
        .clearErrors  (clearErrors),
        .dataAvailable(dataAvailable),
        .fullError    (fullError),
        .emptyError   (emptyError),
        .fx3Ready     (fx3Ready),
        .collectData  (collectData),
        .readData     (readData),
        .fx3DataValid (fx3DataValid),
        .fx3EndOfBurst(fx3EndOfBurst),
        .errorFlags   (errorFlags),
        .burstCount   (burstCount)
    );

    always #5 fx3Clk = ~fx3Clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: words in flight are a queue of (due cycle, last) pairs.
    typedef struct { int due; bit last; } word_t;
    word_t       inflight[$];
    int          m_mode  = M_IDLE;
    int          m_left  = 0;
    int          m_drain = 0;
    logic [1:0]  m_flags = 2'b00;
    logic        m_collect = 1'b0;
    logic [15:0] m_bcnt = 16'd0;
    int          cyc = 0;

    int mon_reads, mon_valids, mon_eobs, mon_stall_valids;
    int first_read, last_read, first_valid, last_valid, eob_cyc;

    bit         e_req, e_ovf, e_unf, e_rd, e_v, e_l;
    logic [1:0] e_nf;

    always @(negedge fx3Clk) begin
        e_req = (m_mode == M_BURST) && fx3Ready && (m_flags == 2'b00);
        e_ovf = fullError && m_collect;
        e_unf = emptyError && e_req;
        e_rd  = e_req && !e_ovf && !e_unf;
        e_v   = 1'b0;
        e_l   = 1'b0;
        if (inflight.size() > 0 && inflight[0].due == cyc) begin
            e_v = 1'b1;
            e_l = inflight[0].last;
            void'(inflight.pop_front());
        end

        check("readData", readData, e_rd);
        check("fx3DataValid", fx3DataValid, e_v);
        check("fx3EndOfBurst", fx3EndOfBurst, e_l);
        check("errorFlags", errorFlags, m_flags);
        check("collectData", collectData, m_collect);
        check("burstCount", burstCount, m_bcnt);

        if (readData) begin
            mon_reads++;
            if (first_read < 0) first_read = cyc;
            last_read = cyc;
        end
        if (fx3DataValid) begin
            mon_valids++;
            if (first_valid < 0) first_valid = cyc;
            last_valid = cyc;
            if (!fx3Ready) mon_stall_valids++;
        end
        if (fx3EndOfBurst) begin
            mon_eobs++;
            eob_cyc = cyc;
        end

        if (!nReset) begin
            m_mode = M_IDLE; m_flags = 2'b00; m_collect = 1'b0; m_bcnt = 16'd0;
            m_left = 0; m_drain = 0;
            inflight.delete();
        end else begin
            if (e_l) m_bcnt = m_bcnt + 16'd1;
            if (e_rd) inflight.push_back('{cyc + RL, (m_left == 1)});
            e_nf = (clearErrors ? 2'b00 : m_flags) | {e_unf, e_ovf};
            m_collect = collectEnable && (e_nf == 2'b00);
            if (e_ovf || e_unf) m_mode = M_ERROR;
            else begin
                case (m_mode)
                    M_IDLE:  if (dataAvailable && collectEnable && m_flags == 2'b00) m_mode = M_WAIT;
                    M_WAIT:  if (fx3Ready) begin m_mode = M_BURST; m_left = BL; end
                    M_BURST: if (e_rd) begin
                                 m_left--;
                                 if (m_left == 0) begin m_mode = M_DRAIN; m_drain = RL; end
                             end
                    M_DRAIN: begin m_drain--; if (m_drain == 0) m_mode = M_IDLE; end
                    default: if (m_flags == 2'b00 && !collectEnable) m_mode = M_IDLE;
                endcase
            end
            m_flags = e_nf;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge fx3Clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_reads = 0; mon_valids = 0; mon_eobs = 0; mon_stall_valids = 0;
        first_read = -1; last_read = -1; first_valid = -1; last_valid = -1; eob_cyc = -1;
    endtask

    task automatic pulse_dav();
        dataAvailable = 1'b1;
        tick();
        dataAvailable = 1'b0;
    endtask

    task automatic wait_reads(input int n);
        int b = 0;
        while (mon_reads < n && b < 200) begin
            @(posedge fx3Clk);
            b++;
        end
        check("wait_reads_bound", (mon_reads >= n), 1);
    endtask

    task automatic wait_eob(input int n);
        int b = 0;
        while (mon_eobs < n && b < 200) begin
            tick();
            b++;
        end
        check("wait_eob_bound", (mon_eobs >= n), 1);
        repeat (3) tick();
    endtask

    int dav_cyc;
    logic [15:0] exp_wrap [3];

    initial begin
        clear_mon();
        repeat (3) tick();
        nReset = 1'b1;
        @(negedge fx3Clk);
        check("rst_flags", errorFlags, 0);
        check("rst_count", burstCount, 0);
        check("rst_valid", fx3DataValid, 0);
        check("rst_collect", collectData, 0);
        tick();

        // Uninterrupted burst
        collectEnable = 1'b1;
        tick(); tick();
        clear_mon();
        dav_cyc = cyc;
        pulse_dav();
        wait_eob(1);
        check("t1_reads", mon_reads, 16);
        check("t1_valids", mon_valids, 16);
        check("t1_eobs", mon_eobs, 1);
        check("t1_read_lat", first_read - dav_cyc, 2);
        check("t1_valid_lat", first_valid - first_read, 2);
        check("t1_eob_on_last", eob_cyc, last_valid);
        check("t1_count", burstCount, 1);

        // FX3 back-pressure for 3 cycles after read 5
        clear_mon();
        pulse_dav();
        wait_reads(5);
        #1 fx3Ready = 1'b0;
        repeat (3) @(posedge fx3Clk);
        #1 fx3Ready = 1'b1;
        wait_eob(1);
        check("t2_reads", mon_reads, 16);
        check("t2_valids", mon_valids, 16);
        check("t2_eobs", mon_eobs, 1);
        check("t2_read_gap", (last_read - first_read + 1) - mon_reads, 3);
        check("t2_stall_valids", mon_stall_valids, 2);
        check("t2_count", burstCount, 2);

        // Overflow during a burst
        clear_mon();
        pulse_dav();
        wait_reads(3);
        #1 fullError = 1'b1;
        @(negedge fx3Clk);
        check("t3_read_gated", readData, 0);
        @(posedge fx3Clk);
        #1 fullError = 1'b0;
        @(negedge fx3Clk);
        check("t3_flags", errorFlags, 1);
        check("t3_collect_off", collectData, 0);
        repeat (5) tick();
        check("t3_reads", mon_reads, 3);
        check("t3_flushed", mon_valids, 3);
        check("t3_no_eob", mon_eobs, 0);
        collectEnable = 1'b0;
        clearErrors = 1'b1;
        tick();
        clearErrors = 1'b0;
        tick();
        check("t3_cleared", errorFlags, 0);

        // Overflow and underflow together
        collectEnable = 1'b1;
        tick(); tick();
        clear_mon();
        pulse_dav();
        wait_reads(4);
        #1 fullError = 1'b1; emptyError = 1'b1;
        @(posedge fx3Clk);
        #1 fullError = 1'b0; emptyError = 1'b0;
        @(negedge fx3Clk);
        check("t4_flags", errorFlags, 3);
        tick();
        collectEnable = 1'b0;
        clearErrors = 1'b1;
        tick();
        clearErrors = 1'b0;
        tick();
        check("t4_cleared", errorFlags, 0);
        check("t4_collect", collectData, 0);
        tick(); tick();
        collectEnable = 1'b1;
        clear_mon();
        dav_cyc = cyc;
        pulse_dav();
        wait_eob(1);
        check("t4_reads_after", mon_reads, 16);
        check("t4_read_lat", first_read - dav_cyc, 2);
        check("t4_count", burstCount, 3);

        // Reset asserted on read 7
        clear_mon();
        pulse_dav();
        wait_reads(6);
        #1 nReset = 1'b0; collectEnable = 1'b0;
        tick();
        nReset = 1'b1;
        clear_mon();
        @(negedge fx3Clk);
        check("t5_read", readData, 0);
        check("t5_valid", fx3DataValid, 0);
        check("t5_eob", fx3EndOfBurst, 0);
        check("t5_flags", errorFlags, 0);
        check("t5_count", burstCount, 0);
        check("t5_collect", collectData, 0);
        repeat (8) tick();
        check("t5_no_valid", mon_valids, 0);

        // Random traffic
        for (int i = 0; i < 2500; i++) begin
            nReset        = ($urandom_range(0, 499) != 0);
            collectEnable = ($urandom_range(0, 9) != 0);
            dataAvailable = ($urandom_range(0, 9) < 3);
            fx3Ready      = ($urandom_range(0, 9) < 8);
            fullError     = ($urandom_range(0, 199) == 0);
            emptyError    = ($urandom_range(0, 199) == 0);
            clearErrors   = ($urandom_range(0, 19) == 0);
            tick();
        end
        collectEnable = 1'b0; dataAvailable = 1'b0; fx3Ready = 1'b1;
        fullError = 1'b0; emptyError = 1'b0; clearErrors = 1'b0;
        nReset = 1'b0;
        tick(); tick();
        nReset = 1'b1;
        tick();

        // Counter wrap from a preloaded value
        force dut.burst_count_q = 16'hFFFE;
        m_bcnt = 16'hFFFE;
        tick();
        release dut.burst_count_q;
        @(negedge fx3Clk);
        check("wrap_preload", burstCount, 16'hFFFE);
        tick();
        collectEnable = 1'b1;
        tick();
        exp_wrap[0] = 16'hFFFF;
        exp_wrap[1] = 16'h0000;
        exp_wrap[2] = 16'h0001;
        for (int k = 0; k < 3; k++) begin
            clear_mon();
            pulse_dav();
            wait_eob(1);
            check("wrap_count", burstCount, exp_wrap[k]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
